// File: rtl/part_updn_counter.sv
// Presettable up/down counter with a programmable terminal value, wrap or
// saturate behaviour at the terminal, and an active-low ripple carry for cascading.
module part_updn_counter #(
    parameter int unsigned          WIDTH = 16,
    parameter logic [WIDTH-1:0]     INIT  = '0
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [WIDTH-1:0] I,
    input  logic [WIDTH-1:0] LIMIT,
    input  logic             LOAD_N,
    input  logic             ENB_P_N,
    input  logic             ENB_T_N,
    input  logic             UP_DN,
    input  logic             SAT,
    output logic [WIDTH-1:0] O,
    output logic             CO_N,
    output logic             WRAP,
    output logic             OVF
);

    logic [WIDTH-1:0] count_q;
    logic             wrap_q;
    logic             ovf_q;
    logic             term;
    logic             count_en;

    // An up-count treats anything at or above LIMIT as terminal, so a value
    // loaded above the limit rolls over on its next count instead of running on.
    always_comb begin
        // NOTE: combinational blocks assign a default first so no path leaves
        // a signal unassigned, which is what would otherwise infer a latch.
        term = 1'b0;
        if (UP_DN) begin
            term = (count_q >= LIMIT);
        end else begin
            term = (count_q == '0);
        end
    end

    assign count_en = LOAD_N && !ENB_P_N && !ENB_T_N;

    // Carry is purely combinational so a chain of stages ripples within one cycle.
    assign CO_N = !(!ENB_T_N && term);

    always_ff @(posedge CLK) begin
        // NOTE: registers use non-blocking assignments so every flop samples
        // pre-edge values; blocking here would create order-dependent logic.
        if (RESET) begin
            count_q <= INIT;
            wrap_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (!LOAD_N) begin
            count_q <= I;
            wrap_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (count_en) begin
            if (!term) begin
                count_q <= UP_DN ? count_q + WIDTH'(1) : count_q - WIDTH'(1);
                wrap_q  <= 1'b0;
            end else if (!SAT) begin
                count_q <= UP_DN ? '0 : LIMIT;
                wrap_q  <= 1'b1;
            end else begin
                wrap_q  <= 1'b0;
                ovf_q   <= 1'b1;
            end
        end else begin
            wrap_q <= 1'b0;
        end
    end

    assign O    = count_q;
    assign WRAP = wrap_q;
    assign OVF  = ovf_q;

endmodule

// File: tb/tb_part_updn_counter.sv
// Self-checking bench for part_updn_counter: directed scenarios, a randomised
// phase against a reference model, and a two-stage cascade.
module tb_part_updn_counter;

    localparam int W = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic [W-1:0] din;
    logic [W-1:0] lim;
    logic         load_n;
    logic         enp_n;
    logic         ent_n;
    logic         up;
    logic         sat;
    logic [W-1:0] o;
    logic         co_n;
    logic         wrap;
    logic         ovf;

    part_updn_counter #(.WIDTH(W), .INIT(4'd0)) dut (
        .CLK(clk), .RESET(rst), .I(din), .LIMIT(lim), .LOAD_N(load_n),
        .ENB_P_N(enp_n), .ENB_T_N(ent_n), .UP_DN(up), .SAT(sat),
        .O(o), .CO_N(co_n), .WRAP(wrap), .OVF(ovf)
    );

    // Cascade pair: lower carry drives the upper T enable.
    logic         cas_rst;
    logic         cas_enp_n;
    logic [W-1:0] lo_o, hi_o;
    logic         lo_co_n, hi_co_n;
    logic         lo_wrap, hi_wrap, lo_ovf, hi_ovf;

    part_updn_counter #(.WIDTH(W), .INIT(4'd0)) cas_lo (
        .CLK(clk), .RESET(cas_rst), .I(4'd0), .LIMIT(4'hF), .LOAD_N(1'b1),
        .ENB_P_N(cas_enp_n), .ENB_T_N(1'b0), .UP_DN(1'b1), .SAT(1'b0),
        .O(lo_o), .CO_N(lo_co_n), .WRAP(lo_wrap), .OVF(lo_ovf)
    );

    part_updn_counter #(.WIDTH(W), .INIT(4'd0)) cas_hi (
        .CLK(clk), .RESET(cas_rst), .I(4'd0), .LIMIT(4'hF), .LOAD_N(1'b1),
        .ENB_P_N(cas_enp_n), .ENB_T_N(lo_co_n), .UP_DN(1'b1), .SAT(1'b0),
        .O(hi_o), .CO_N(hi_co_n), .WRAP(hi_wrap), .OVF(hi_ovf)
    );

    typedef struct {
        string        tag;
        logic [W-1:0] o;
        logic         wrap;
        logic         ovf;
        logic         co_n;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    // Reference model state for the randomised phase.
    int   m_o;
    bit   m_ovf;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, want);
        end
    endtask

    task automatic drive(input logic r, input logic ld_n, input logic p_n, input logic t_n,
                         input logic u, input logic s, input logic [W-1:0] d,
                         input logic [W-1:0] l);
        rst    = r;
        load_n = ld_n;
        enp_n  = p_n;
        ent_n  = t_n;
        up     = u;
        sat    = s;
        din    = d;
        lim    = l;
    endtask

    // Advance one edge, then pop the oldest expectation and compare it.
    task automatic tick_and_compare();
        exp_t e;
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check("scoreboard_underflow", 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            check({e.tag, ".O"},    32'(o),    32'(e.o));
            check({e.tag, ".WRAP"}, 32'(wrap), 32'(e.wrap));
            check({e.tag, ".OVF"},  32'(ovf),  32'(e.ovf));
            check({e.tag, ".CO_N"}, 32'(co_n), 32'(e.co_n));
        end
    endtask

    task automatic step(input string tag, input int eo, input bit ew, input bit ev, input bit ec);
        exp_t e;
        e.tag  = tag;
        e.o    = W'(eo);
        e.wrap = ew;
        e.ovf  = ev;
        e.co_n = ec;
        sb.push_back(e);
        tick_and_compare();
    endtask

    // Independent model of one edge for the randomised phase.
    task automatic model_step(input string tag);
        bit term_pre;
        bit w;
        bit term_post;
        w = 1'b0;
        term_pre = up ? (m_o >= int'(lim)) : (m_o == 0);
        if (rst) begin
            m_o   = 0;
            m_ovf = 1'b0;
        end else if (!load_n) begin
            m_o   = int'(din);
            m_ovf = 1'b0;
        end else if (!enp_n && !ent_n) begin
            if (!term_pre) begin
                m_o = up ? (m_o + 1) % 16 : (m_o + 15) % 16;
            end else if (!sat) begin
                m_o = up ? 0 : int'(lim);
                w   = 1'b1;
            end else begin
                m_ovf = 1'b1;
            end
        end
        term_post = up ? (m_o >= int'(lim)) : (m_o == 0);
        step(tag, m_o, w, m_ovf, !(!ent_n && term_post));
    endtask

    initial begin
        cas_rst   = 1'b1;
        cas_enp_n = 1'b1;
        drive(1, 1, 1, 1, 1, 0, 4'd0, 4'd9);
        step("reset", 0, 0, 0, 1);

        // Decade up-count: 1..9, 0, 1, 2.
        drive(0, 1, 0, 0, 1, 0, 4'd0, 4'd9);
        for (int k = 1; k <= 12; k++) begin
            step($sformatf("decade%0d", k), k % 10, k == 10, 0, (k % 10 == 9) ? 1'b0 : 1'b1);
        end

        // Down wrap from 1: 0, 9, 8.
        drive(0, 0, 1, 1, 0, 0, 4'd1, 4'd9);
        step("dn_load", 1, 0, 0, 1);
        drive(0, 1, 0, 0, 0, 0, 4'd0, 4'd9);
        step("dn_0", 0, 0, 0, 0);
        step("dn_9", 9, 1, 0, 1);
        step("dn_8", 8, 0, 0, 1);

        // Saturation, then a load that clears OVF while still at the terminal.
        drive(0, 0, 1, 1, 1, 1, 4'd14, 4'd15);
        step("sat_load", 14, 0, 0, 1);
        drive(0, 1, 0, 0, 1, 1, 4'd0, 4'd15);
        step("sat_1", 15, 0, 0, 0);
        step("sat_2", 15, 0, 1, 0);
        step("sat_3", 15, 0, 1, 0);
        drive(0, 0, 0, 0, 1, 1, 4'd3, 4'd15);
        step("sat_clr", 3, 0, 0, 1);

        // Priority: reset over load, load over disabled count, T gates carry.
        drive(1, 0, 0, 0, 1, 1, 4'd7, 4'd15);
        step("pri_rst", 0, 0, 0, 1);
        drive(0, 0, 1, 0, 1, 1, 4'd7, 4'd15);
        step("pri_load", 7, 0, 0, 1);
        drive(0, 0, 1, 1, 1, 1, 4'd15, 4'd15);
        step("pri_t_up", 15, 0, 0, 1);
        drive(0, 0, 1, 1, 0, 1, 4'd0, 4'd15);
        step("pri_t_dn", 0, 0, 0, 1);

        // Reset while saturated with count enabled.
        drive(0, 0, 1, 1, 1, 1, 4'd15, 4'd15);
        step("rsat_load", 15, 0, 0, 1);
        drive(0, 1, 0, 0, 1, 1, 4'd0, 4'd15);
        step("rsat_ovf", 15, 0, 1, 0);
        drive(1, 1, 0, 0, 1, 1, 4'd0, 4'd15);
        step("rsat_rst", 0, 0, 0, 1);

        // Loaded value above the limit.
        drive(0, 0, 1, 1, 1, 0, 4'd12, 4'd5);
        step("abv_load_up", 12, 0, 0, 1);
        drive(0, 1, 0, 0, 1, 0, 4'd0, 4'd5);
        step("abv_up", 0, 1, 0, 1);
        drive(0, 0, 1, 1, 0, 0, 4'd12, 4'd5);
        step("abv_load_dn", 12, 0, 0, 1);
        drive(0, 1, 0, 0, 0, 0, 4'd0, 4'd5);
        step("abv_dn", 11, 0, 0, 1);

        // LIMIT=0: every count wraps in both directions; then hold.
        drive(0, 1, 0, 0, 1, 0, 4'd0, 4'd0);
        step("lim0_up1", 0, 1, 0, 0);
        step("lim0_up2", 0, 1, 0, 0);
        drive(0, 1, 0, 0, 0, 0, 4'd0, 4'd0);
        step("lim0_dn", 0, 1, 0, 0);
        drive(0, 1, 1, 0, 0, 0, 4'd0, 4'd0);
        step("hold", 0, 0, 0, 0);

        // Randomised phase against the reference model.
        drive(1, 1, 1, 1, 1, 0, 4'd0, 4'd0);
        m_o   = 5;
        m_ovf = 1'b1;
        model_step("rnd_rst");
        for (int n = 0; n < 400; n++) begin
            drive(($urandom_range(0, 31) == 0), ($urandom_range(0, 7) != 0),
                  ($urandom_range(0, 4) == 0), ($urandom_range(0, 4) == 0),
                  1'($urandom), 1'($urandom), W'($urandom), W'($urandom));
            model_step($sformatf("rnd%0d", n));
        end

        // Cascade: 256 counts through the combined 8-bit value.
        drive(0, 1, 1, 1, 1, 0, 4'd0, 4'd0);
        @(posedge clk);
        #1;
        check("cas_rst_val", 32'({hi_o, lo_o}), 32'd0);
        check("cas_rst_co", 32'(hi_co_n), 32'd1);
        cas_rst   = 1'b0;
        cas_enp_n = 1'b0;
        for (int k = 1; k <= 256; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("cas_val%0d", k), 32'({hi_o, lo_o}), 32'(k % 256));
            check($sformatf("cas_co%0d", k), 32'(hi_co_n), (k % 256 == 255) ? 32'd0 : 32'd1);
        end

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/part_updn_counter.md
PART_UPDN_COUNTER -- requirements
Module: part_updn_counter

Interface
REQ-001 Parameter: WIDTH, default 16, counter width in bits (legal 2..32).
REQ-002 Parameter: INIT, default 0, value placed in O on reset (WIDTH bits).
REQ-003 CLK  input  1  single clock; all state changes on rising edge.
REQ-004 RESET  input  1  synchronous, active-high reset.
REQ-005 I  input  WIDTH  parallel load data.
REQ-006 LIMIT  input  WIDTH  programmable terminal value (modulus = LIMIT+1).
REQ-007 LOAD_N  input  1  active-low synchronous parallel load.
REQ-008 ENB_P_N  input  1  active-low count enable P.
REQ-009 ENB_T_N  input  1  active-low count enable T; also gates CO_N.
REQ-010 UP_DN  input  1  direction: 1 = up, 0 = down.
REQ-011 SAT  input  1  terminal mode: 1 = saturate, 0 = wrap.
REQ-012 O  output  WIDTH  registered count value.
REQ-013 CO_N  output  1  active-low ripple carry for cascading, combinational from O, UP_DN, LIMIT, ENB_T_N.
REQ-014 WRAP  output  1  registered one-cycle pulse: previous cycle's count wrapped.
REQ-015 OVF  output  1  registered sticky flag: count attempted while saturated.

Function
REQ-016 Terminal condition TERM SHALL be: UP_DN=1 and O>=LIMIT (unsigned), or UP_DN=0 and O==0.
REQ-017 CO_N SHALL be 0 iff ENB_T_N=0 and TERM=1; else 1; no register delay.
REQ-018 Per-edge priority SHALL be: RESET, then LOAD_N=0, then count, then hold.
REQ-019 Load: LOAD_N=0 SHALL set O<=I regardless of ENB_P_N, ENB_T_N, UP_DN, SAT.
REQ-020 Count cycle SHALL occur iff RESET=0, LOAD_N=1, ENB_P_N=0, ENB_T_N=0.
REQ-021 Count, TERM=0: O<=O+1 if UP_DN=1, O<=O-1 if UP_DN=0 (modulo 2^WIDTH, never reached due to TERM).
REQ-022 Count, TERM=1, SAT=0: up SHALL set O<=0, down SHALL set O<=LIMIT; WRAP<=1 next cycle.
REQ-023 Count, TERM=1, SAT=1: O SHALL hold; OVF<=1.
REQ-024 WRAP SHALL be 0 on every edge not matching REQ-022 (pulse width exactly one cycle; back-to-back wraps give consecutive 1s).
REQ-025 OVF SHALL stay 1 until RESET or a load cycle clears it; a load SHALL clear OVF even if simultaneous with saturation conditions.
REQ-026 Loaded value above LIMIT: up-count SHALL wrap/saturate at next count (O>=LIMIT is TERM); down-count SHALL decrement normally toward 0.
REQ-027 LIMIT=0: up and down wrap both SHALL produce O=0 each count; WRAP=1 each count cycle in wrap mode.
REQ-028 UP_DN, SAT, LIMIT changes SHALL take effect on the very next edge; no pipelining of controls.
REQ-029 Hold (enables not both low, LOAD_N=1): O and OVF unchanged, WRAP<=0.
REQ-030 Cascade: stage k ENB_T_N driven by stage k-1 CO_N SHALL give a correct 2*WIDTH counter when all LIMIT=2^WIDTH-1.

Reset
REQ-031 RESET=1 at an edge SHALL set O<=INIT, WRAP<=0, OVF<=0, overriding load and count, including mid-count or mid-saturation.
REQ-032 CO_N after reset SHALL reflect INIT combinationally per REQ-017; no X on any output after first reset edge.

Verification (WIDTH=4, INIT=0 unless stated)
REQ-033 Decade up: LIMIT=9, SAT=0, UP_DN=1, enables low, 12 edges -> O 1..9,0,1,2; CO_N=0 while O=9; WRAP=1 the cycle O=0.
REQ-034 Down wrap: LIMIT=9, load I=1, UP_DN=0, 3 counts -> O 0,9,8; CO_N=0 at O=0; WRAP pulses once at O=9.
REQ-035 Saturate: SAT=1, LIMIT=15, load I=14, up 3 counts -> O 15,15,15; OVF=1 from second count; load I=3 -> O=3, OVF=0.
REQ-036 Priority: RESET=1 with LOAD_N=0, I=7 -> O=0; then LOAD_N=0, ENB_P_N=1, I=7 -> O=7; ENB_T_N=1 -> CO_N=1 at any O.
REQ-037 Above-limit: LIMIT=5, load I=12, one up count -> O=0, WRAP=1; load I=12, one down count -> O=11.
REQ-038 Cascade: two instances, LIMIT=15, lower CO_N to upper ENB_T_N, 256 counts from 0 -> combined 0x00..0xFF then 0x00, upper CO_N=0 only at 0xFF.
